// File: rtl/dynamic_root_calculator_if.sv
// Request/result bundle for the n-th root unit: the requester drives the
// operands and start, the root unit drives status and result.
interface dynamic_root_calculator_if #(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 5
);
  logic                 start;
  logic [WIDTH-1:0]     value;
  logic [EXP_WIDTH-1:0] n;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     root;
  logic                 exact;
  logic                 err;

  modport master (
    output start, value, n,
    input  busy, done, root, exact, err
  );

  modport slave (
    input  start, value, n,
    output busy, done, root, exact, err
  );
endinterface

// File: rtl/dynamic_root_calculator.sv
// Iterative floor n-th root: bitwise binary search over the root, with each
// candidate raised to the n-th power by repeated saturating multiplication.
module dynamic_root_calculator #(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  dynamic_root_calculator_if.slave bus
);
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, TRY, MUL, CMP, FIN} state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_value;
  logic [EXP_WIDTH-1:0] r_n;
  logic [EXP_WIDTH-1:0] r_k;
  logic [BW-1:0]        r_bit;
  logic [WIDTH-1:0]     r_p;
  logic [WIDTH-1:0]     r_cand;
  logic [2*WIDTH-1:0]   r_acc;
  logic                 r_over;
  logic                 r_eq;
  logic                 r_errPend;
  logic                 r_busy;
  logic                 r_done;
  logic [WIDTH-1:0]     r_root;
  logic                 r_exact;
  logic                 r_err;

  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_valueWide;

  // r_acc never exceeds V before a multiply, so the product fits in 2*WIDTH
  assign w_prod      = r_acc * {{WIDTH{1'b0}}, r_cand};
  assign w_valueWide = {{WIDTH{1'b0}}, r_value};

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.root  = r_root;
  assign bus.exact = r_exact;
  assign bus.err   = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_value   <= '0;
      r_n       <= '0;
      r_k       <= '0;
      r_bit     <= '0;
      r_p       <= '0;
      r_cand    <= '0;
      r_acc     <= '0;
      r_over    <= 1'b0;
      r_eq      <= 1'b0;
      r_errPend <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_root    <= '0;
      r_exact   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_value   <= bus.value;
            r_n       <= bus.n;
            r_busy    <= 1'b1;
            r_errPend <= 1'b0;
            if (bus.n == '0) begin
              r_errPend <= 1'b1;
              r_p       <= '0;
              r_eq      <= 1'b0;
              r_state   <= FIN;
            end else if (bus.n == EXP_WIDTH'(1)) begin
              r_p     <= bus.value;
              r_eq    <= 1'b1;
              r_state <= FIN;
            end else begin
              r_bit   <= BW'(WIDTH - 1);
              r_p     <= '0;
              r_eq    <= (bus.value == '0);
              r_state <= TRY;
            end
          end
        end
        TRY: begin
          r_cand  <= r_p | (WIDTH'(1) << r_bit);
          r_acc   <= (2*WIDTH)'(1);
          r_over  <= 1'b0;
          r_k     <= '0;
          r_state <= MUL;
        end
        MUL: begin
          // Once over V the power is only known to be too large; acc is frozen
          if (!r_over) begin
            if (w_prod > w_valueWide) begin
              r_over <= 1'b1;
            end else begin
              r_acc <= w_prod;
            end
          end
          if (r_k == r_n - EXP_WIDTH'(1)) begin
            r_state <= CMP;
          end else begin
            r_k <= r_k + EXP_WIDTH'(1);
          end
        end
        CMP: begin
          if (!r_over) begin
            r_p  <= r_cand;
            r_eq <= (r_acc == w_valueWide);
          end
          if (r_bit == '0) begin
            r_state <= FIN;
          end else begin
            r_bit   <= r_bit - BW'(1);
            r_state <= TRY;
          end
        end
        FIN: begin
          r_root  <= r_p;
          r_exact <= r_eq;
          r_err   <= r_errPend;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/dynamic_root_calculator.md
Name: dynamic_root_calculator

Overview:
Iterative integer n-th root unit, the inverse of the dynamic power calculator. Given value V and exponent n, it returns the floor root r, the largest r with r^n <= V. It uses bitwise binary search over the root, computing each candidate power by repeated multiplication with saturation. It sits beside the power calculator in the scalar-field datapath and recovers the base operand from a powered result.

Parameters:
WIDTH, 32, width of value and root.
EXP_WIDTH, 5, width of exponent n (n in 0..2^EXP_WIDTH-1).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  reset, asynchronous, active-high.
start  input  1  request pulse; sampled only in IDLE.
value  input  WIDTH  operand V; captured on accepted start.
n  input  EXP_WIDTH  root degree; captured on accepted start.
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  one-cycle pulse when root/exact/err are valid.
root  output  WIDTH  floor n-th root of V.
exact  output  1  1 when root^n == V.
err  output  1  1 when n == 0 (undefined root).

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, root=0, exact=0, err=0; internal registers cleared. Reset mid-operation abandons the computation, and no done is produced.
- States: IDLE, TRY, MUL, CMP, FIN.
- IDLE: start=1 captures V, n, sets busy. Next state:
  - n==0 -> FIN with err=1, root=0.
  - n==1 -> FIN with root=V.
  - else: bit index b=WIDTH-1, partial root p=0, eq=(V==0); go to TRY.
- TRY (1 cycle): candidate c = p | (1<<b); acc=1 (2*WIDTH bits); over=0; k=0; go to MUL.
- MUL (exactly n cycles, k=0..n-1): if over=0, acc=acc*c; if the result > V, set over=1 and hold acc. acc never exceeds 2*WIDTH bits because acc<=V before each multiply. After the n-th cycle, go to CMP.
- CMP (1 cycle): if over=0 (c^n <= V), then p=c and eq=(acc==V). If b==0 go to FIN, else b=b-1 and go to TRY.
- FIN (1 cycle): root=p (or the special-case value), exact=eq (n==1: exact=1; n==0: exact=0), err as set; done=1; busy=0; go to IDLE.
- Latency, accepted start edge to the done-high cycle:
  - n>=2: WIDTH*(n+2)+1 cycles.
  - n==0 or n==1: 1 cycle.
- start while busy is ignored; no queueing. start in the FIN cycle is also ignored. A new start may be accepted the cycle after done.
- root, exact and err update only in FIN and hold their values between operations. done is high for exactly one cycle per accepted start.
- value/n changes after acceptance have no effect.
- V=0: root=0, exact=1 for n>=1.
- V=2^WIDTH-1: no wrap; saturation via over guarantees a correct compare.

Test Plan:
- V=1000, n=3, start pulse -> done exactly 161 cycles later; root=10, exact=1, err=0; busy high for the whole interval.
- V=999, n=3 -> root=9, exact=0; V=0xFFFFFFFF, n=2 -> root=65535, exact=0 (checks saturation at 65536^2 = 2^32).
- n=0, V=77 -> done after 1 cycle, err=1, root=0, exact=0. n=1, V=12345 -> done after 1 cycle, root=12345, exact=1.
- V=0x80000000, n=31 -> root=2, exact=1, done after 1057 cycles. V=0, n=5 -> root=0, exact=1.
- V=64, n=2 started, then start with V=9 asserted on cycle 10 while busy -> ignored; result root=8, exact=1; single done pulse.
- V=1000, n=3 started, reset asserted on cycle 50 -> immediately busy=0, root=0, done=0, no done pulse. A new start with V=27, n=3 after reset release -> root=3, exact=1.
